// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: load/store initiator for a word-addressed data memory.
// It does sub-word extraction for loads and read-modify-write for byte and halfword stores.
module dmem_access_ctrl #(
    parameter int TAG_W       = 4,
    parameter int DEPTH_WORDS = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_sign,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [TAG_W-1:0] resp_tag,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    output logic             mem_we,
    output logic [31:0]      mem_a,
    output logic [31:0]      mem_wd,
    input  logic [31:0]      mem_rd
);
    typedef enum logic [2:0] {IDLE, LD, RMW_RD, WR, RESP} state_t;
    state_t      state;
    logic [31:0] addr_q, merge_q;
    logic [15:0] wdata_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic        req_err;
    logic [4:0]  bsh;
    logic [7:0]  rb;
    logic [15:0] rh;
    logic [31:0] ld_val, lane_mask, lane_data;
    always_comb begin
        req_err   = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0])
                    || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                    || req_addr[31:2] >= 30'(DEPTH_WORDS);
        bsh       = size_q[0] ? {addr_q[1], 4'b0000} : {addr_q[1:0], 3'b000};
        rb        = 8'(mem_rd >> bsh);
        rh        = 16'(mem_rd >> bsh);
        ld_val    = size_q == 2'b10 ? mem_rd
                  : size_q[0] ? {{16{sign_q & rh[15]}}, rh} : {{24{sign_q & rb[7]}}, rb};
        lane_mask = (size_q[0] ? 32'h0000_ffff : 32'h0000_00ff) << bsh;
        lane_data = (size_q[0] ? {16'h0, wdata_q} : {24'h0, wdata_q[7:0]}) << bsh;
    end
    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
    assign mem_we     = state == WR;
    assign mem_a      = (state == LD || state == RMW_RD || state == WR) ? {addr_q[31:2], 2'b00} : '0;
    assign mem_wd     = state == WR ? merge_q : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            merge_q    <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            sign_q     <= 1'b0;
            resp_tag   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr_q     <= req_addr;
                    size_q     <= req_size;
                    sign_q     <= req_sign;
                    wdata_q    <= req_wdata[15:0];
                    merge_q    <= req_wdata;
                    resp_tag   <= req_tag;
                    resp_err   <= req_err;
                    resp_rdata <= '0;
                    state      <= req_err ? RESP : !req_we ? LD : req_size == 2'b10 ? WR : RMW_RD;
                end
                LD: begin
                    resp_rdata <= ld_val;
                    state      <= RESP;
                end
                RMW_RD: begin
                    merge_q <= (mem_rd & ~lane_mask) | lane_data;
                    state   <= WR;
                end
                WR:      state <= RESP;
                RESP:    if (resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
